// File: rtl/adder_selftest_pkg.sv
// Shared types and helpers for the prefix-adder self-test harness.
//   state_e    : controller states (IDLE/RUN/DRAIN/DONE)
//   MODE_*     : stimulus source selectors
//   lfsr_taps  : Fibonacci tap masks (bit i set = stage i+1 tapped), n = 8..32
package adder_selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int MODE_EXHAUSTIVE = 0;
    localparam int MODE_LFSR       = 1;

    function automatic logic [31:0] lfsr_taps(input int n);
        logic [31:0] t;
        case (n)
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/selftest_vecgen.sv
// Operand-pair generator for the adder self-test.
//   clk, rst  : clock, synchronous active-high reset (vector cleared to 0)
//   load      : reload the first vector (0 in exhaustive mode, SEED in LFSR mode)
//   advance   : step to the next vector
//   vec       : current {a, b} pair, 2*WIDTH bits
//   last      : current vector is the final one of the run
module selftest_vecgen
    import adder_selftest_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          MODE        = MODE_EXHAUSTIVE,
    parameter int          NUM_VECTORS = 1024,
    parameter int unsigned SEED        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    output logic [2*WIDTH-1:0]   vec,
    output logic                 last
);

    localparam int VW = 2 * WIDTH;
    localparam int CW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS + 1) : 1;

    localparam logic [31:0]   TAPS_ALL   = lfsr_taps(VW);
    localparam logic [VW-1:0] TAPS       = TAPS_ALL[VW-1:0];
    localparam logic [VW-1:0] SEED_TRUNC = VW'(SEED);
    // An all-zero seed would lock the LFSR up.
    localparam logic [VW-1:0] SEED_V     = (SEED_TRUNC == '0) ? VW'(1) : SEED_TRUNC;

    logic [VW-1:0] vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        vec_d = vec_q;
        cnt_d = cnt_q;
        if (load) begin
            vec_d = (MODE == MODE_LFSR) ? SEED_V : '0;
            cnt_d = '0;
        end else if (advance) begin
            vec_d = (MODE == MODE_LFSR) ? {vec_q[VW-2:0], ^(vec_q & TAPS)}
                                        : vec_q + VW'(1);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            cnt_q <= '0;
        end else begin
            vec_q <= vec_d;
            cnt_q <= cnt_d;
        end
    end

    // Exhaustive mode ends on all-ones so the index never wraps inside a run.
    assign last = (MODE == MODE_LFSR) ? (cnt_q == CW'(NUM_VECTORS - 1))
                                      : (vec_q == '1);
    assign vec  = vec_q;

endmodule

// File: rtl/adder_wrapper_selftest.sv
// Self-checking stimulus/response engine for registered adder wrappers.
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle run request (honoured in IDLE/DONE)
//   a_out, b_out        : operands to the wrapper (registered)
//   sum_in, cout_in     : wrapper result, LATENCY cycles after the operands
//   busy, done, pass    : run status; pass valid while done
//   err_count           : saturating mismatch count
//   first_err_a/_b/_got : operands and observed {cout,sum} of the first mismatch
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | one vector driven per cycle
// ST_DRAIN | no new vectors, waiting LATENCY cycles for results
// ST_DONE  | results held, waiting for start
module adder_wrapper_selftest
    import adder_selftest_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          LATENCY     = 2,
    parameter int          MODE        = MODE_EXHAUSTIVE,
    parameter int          NUM_VECTORS = 1024,
    parameter int unsigned SEED        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH:0]   first_err_got
);

    localparam int VW = 2 * WIDTH;
    localparam int DW = $clog2(LATENCY) + 1;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             gen_load, gen_advance, gen_last;
    logic [VW-1:0]    gen_vec;

    logic             pv_q   [LATENCY];
    logic [WIDTH:0]   pexp_q [LATENCY];
    logic [WIDTH-1:0] pa_q   [LATENCY];
    logic [WIDTH-1:0] pb_q   [LATENCY];

    logic [15:0]      err_count_q, err_count_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic [WIDTH:0]   fg_q, fg_d;
    logic             pass_q, pass_d;
    logic             mismatch;
    logic [WIDTH:0]   vec_sum;

    selftest_vecgen #(
        .WIDTH       (WIDTH),
        .MODE        (MODE),
        .NUM_VECTORS (NUM_VECTORS),
        .SEED        (SEED)
    ) u_vecgen (
        .clk     (clk),
        .rst     (rst),
        .load    (gen_load),
        .advance (gen_advance),
        .vec     (gen_vec),
        .last    (gen_last)
    );

    assign a_out = gen_vec[VW-1:WIDTH];
    assign b_out = gen_vec[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        gen_load    = 1'b0;
        gen_advance = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    gen_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (gen_last) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(LATENCY - 1);
                end else begin
                    gen_advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - DW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign vec_sum  = {1'b0, a_out} + {1'b0, b_out};
    assign mismatch = pv_q[LATENCY-1] && ({cout_in, sum_in} != pexp_q[LATENCY-1]);

    // Only valid bits are reset; payload is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pv_q[i] <= 1'b0;
        end else begin
            pv_q[0] <= (state_q == ST_RUN);
            for (int i = 1; i < LATENCY; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pexp_q[0] <= vec_sum;
        pa_q[0]   <= a_out;
        pb_q[0]   <= b_out;
        for (int i = 1; i < LATENCY; i++) begin
            pexp_q[i] <= pexp_q[i-1];
            pa_q[i]   <= pa_q[i-1];
            pb_q[i]   <= pb_q[i-1];
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        fa_d        = fa_q;
        fb_d        = fb_q;
        fg_d        = fg_q;
        pass_d      = pass_q;
        if (gen_load) begin
            err_count_d = '0;
            fa_d        = '0;
            fb_d        = '0;
            fg_d        = '0;
            pass_d      = 1'b0;
        end else begin
            if (mismatch) begin
                if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                // A saturating counter is nonzero exactly once a mismatch has been seen.
                if (err_count_q == '0) begin
                    fa_d = pa_q[LATENCY-1];
                    fb_d = pb_q[LATENCY-1];
                    fg_d = {cout_in, sum_in};
                end
            end
            // The final compare lands in the last DRAIN cycle, so use the updated count.
            if (state_q == ST_DRAIN && state_d == ST_DONE) pass_d = (err_count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            fg_q        <= '0;
            pass_q      <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            fg_q        <= fg_d;
            pass_q      <= pass_d;
        end
    end

    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_a   = fa_q;
    assign first_err_b   = fb_q;
    assign first_err_got = fg_q;

endmodule

// File: tb/tb_adder_wrapper_selftest.sv
// Bench for adder_wrapper_selftest: three engines driving behavioural wrapper
// models with controllable latency and planted faults.
//   d0: WIDTH=4, LATENCY=2, exhaustive (N=256)
//   d1: WIDTH=8, LATENCY=2, LFSR, NUM_VECTORS=64, SEED=1, wrapper sum[0] stuck at 0
//   d2: WIDTH=4, LATENCY=3, exhaustive, 3-cycle wrapper
module tb_adder_wrapper_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start1, start2;

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- d0 ----------------
    logic [3:0]  a0, b0, s0, fa0, fb0;
    logic        c0, busy0, done0, pass0;
    logic [15:0] err0;
    logic [4:0]  fg0;
    int          lat0   = 2;
    logic        fault0 = 1'b0;
    logic [7:0]  h0_1, h0_2, h0_3, m0_sel;
    logic [4:0]  m0_r;

    adder_wrapper_selftest #(.WIDTH(4), .LATENCY(2), .MODE(0)) d0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0),
        .sum_in(s0), .cout_in(c0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_a(fa0), .first_err_b(fb0), .first_err_got(fg0));

    always @(posedge clk) begin
        h0_1 <= {a0, b0};
        h0_2 <= h0_1;
        h0_3 <= h0_2;
    end

    always_comb begin
        m0_sel = (lat0 == 3) ? h0_3 : h0_2;
        m0_r   = {1'b0, m0_sel[7:4]} + {1'b0, m0_sel[3:0]};
        if (fault0 && m0_sel == 8'hF1) m0_r[4] = 1'b0;
    end
    assign {c0, s0} = m0_r;

    // ---------------- d1 ----------------
    logic [7:0]  a1, b1, s1, fa1, fb1;
    logic        c1, busy1, done1, pass1;
    logic [15:0] err1;
    logic [8:0]  fg1;
    logic [15:0] h1_1, h1_2;
    logic [8:0]  m1_r;

    adder_wrapper_selftest #(.WIDTH(8), .LATENCY(2), .MODE(1), .NUM_VECTORS(64), .SEED(1)) d1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
        .sum_in(s1), .cout_in(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_a(fa1), .first_err_b(fb1), .first_err_got(fg1));

    always @(posedge clk) begin
        h1_1 <= {a1, b1};
        h1_2 <= h1_1;
    end

    always_comb begin
        m1_r    = {1'b0, h1_2[15:8]} + {1'b0, h1_2[7:0]};
        m1_r[0] = 1'b0;
    end
    assign {c1, s1} = m1_r;

    // ---------------- d2 ----------------
    logic [3:0]  a2, b2, s2, fa2, fb2;
    logic        c2, busy2, done2, pass2;
    logic [15:0] err2;
    logic [4:0]  fg2;
    logic [7:0]  h2_1, h2_2, h2_3;

    adder_wrapper_selftest #(.WIDTH(4), .LATENCY(3), .MODE(0)) d2 (
        .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
        .sum_in(s2), .cout_in(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_a(fa2), .first_err_b(fb2), .first_err_got(fg2));

    always @(posedge clk) begin
        h2_1 <= {a2, b2};
        h2_2 <= h2_1;
        h2_3 <= h2_2;
    end
    assign {c2, s2} = {1'b0, h2_3[7:4]} + {1'b0, h2_3[3:0]};

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        case (which)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [16:0] view_of(input int which);
        case (which)
            0:       return {busy0, 4'h0, a0, 4'h0, b0};
            1:       return {busy1, a1, b1};
            default: return {busy2, 4'h0, a2, 4'h0, b2};
        endcase
    endfunction

    // Pulses start, then counts edges until done; extra start pulses are
    // raised when the edge count equals pulse_a or pulse_b.
    task automatic run_dut(input int which, input int pulse_a, input int pulse_b,
                           input int limit, output int edges, output logic [16:0] first_view);
        drive_start(which, 1'b1);
        @(posedge clk); #1;
        drive_start(which, 1'b0);
        edges      = 0;
        first_view = view_of(which);
        while (!done_of(which) && edges < limit) begin
            drive_start(which, (edges == pulse_a) || (edges == pulse_b));
            @(posedge clk); #1;
            edges++;
        end
        drive_start(which, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          edges;
        logic [16:0] fv;
        logic [15:0] lf;
        logic [7:0]  ma, mb;
        logic [8:0]  msum;
        int          exp_err;
        logic [7:0]  exp_fa, exp_fb;
        logic [8:0]  exp_fg;
        logic        seen;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outs0", {a0, b0, busy0, done0, pass0}, 0);
        check_val("rst_err0", {err0, fa0, fb0, fg0}, 0);
        check_val("rst_outs1", {a1, b1, busy1, done1, pass1, err1}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean exhaustive run with ignored starts in RUN (edge 50) and DRAIN (edge 256).
        run_dut(0, 50, 256, 1000, edges, fv);
        check_val("clean_first_vec", fv, {1'b1, 16'h0000});
        check_val("clean_done_edges", edges, 258);
        check_val("clean_done", done0, 1);
        check_val("clean_busy", busy0, 0);
        check_val("clean_pass", pass0, 1);
        check_val("clean_err", err0, 0);
        check_val("clean_final_ab", {a0, b0}, 8'hFF);

        // cout dropped only for a=F, b=1.
        fault0 = 1'b1;
        run_dut(0, -1, -1, 1000, edges, fv);
        fault0 = 1'b0;
        check_val("cout_done_edges", edges, 258);
        check_val("cout_err", err0, 1);
        check_val("cout_first_a", fa0, 4'hF);
        check_val("cout_first_b", fb0, 4'h1);
        check_val("cout_first_got", fg0, 5'h00);
        check_val("cout_pass", pass0, 0);

        // Wrapper one cycle slower than the engine expects.
        lat0 = 3;
        run_dut(0, -1, -1, 1000, edges, fv);
        lat0 = 2;
        check_val("lat_err_nonzero", err0 >= 16'd255, 1);
        check_val("lat_pass", pass0, 0);

        // Engine configured for the 3-cycle wrapper.
        run_dut(2, -1, -1, 1000, edges, fv);
        check_val("lat3_done_edges", edges, 259);
        check_val("lat3_pass", pass2, 1);
        check_val("lat3_err", err2, 0);

        // LFSR run against sum[0] stuck at 0; model the expected errors.
        lf = 16'h0001; exp_err = 0; seen = 1'b0;
        exp_fa = '0; exp_fb = '0; exp_fg = '0; ma = '0; mb = '0;
        for (int k = 0; k < 64; k++) begin
            ma   = lf[15:8];
            mb   = lf[7:0];
            msum = {1'b0, ma} + {1'b0, mb};
            if (msum[0]) begin
                exp_err++;
                if (!seen) begin
                    seen   = 1'b1;
                    exp_fa = ma;
                    exp_fb = mb;
                    exp_fg = {msum[8:1], 1'b0};
                end
            end
            if (k != 63) lf = {lf[14:0], lf[15] ^ lf[14] ^ lf[12] ^ lf[3]};
        end
        run_dut(1, -1, -1, 1000, edges, fv);
        check_val("lfsr_first_vec", fv, {1'b1, 8'h00, 8'h01});
        check_val("lfsr_done_edges", edges, 66);
        check_val("lfsr_err", err1, exp_err);
        check_val("lfsr_first_a", fa1, exp_fa);
        check_val("lfsr_first_b", fb1, exp_fb);
        check_val("lfsr_first_got", fg1, exp_fg);
        check_val("lfsr_final_ab", {a1, b1}, {ma, mb});
        check_val("lfsr_pass", pass1, 0);

        // Reset in the middle of a run.
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check_val("midrun_busy", busy0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrun_rst_outs", {a0, b0, busy0, done0, pass0}, 0);
        check_val("midrun_rst_err", {err0, fa0, fb0, fg0}, 0);
        @(posedge clk); #1;
        check_val("midrun_idle", {busy0, done0, err0}, 0);
        run_dut(0, -1, -1, 1000, edges, fv);
        check_val("rerun_done_edges", edges, 258);
        check_val("rerun_pass", pass0, 1);
        check_val("rerun_err", err0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adder_wrapper_selftest.md
# adder_wrapper_selftest

Self-checking stimulus/response engine for the registered prefix-adder wrappers. It drives operands into an `adder_<topology>_<W>u_wrapper` instance and receives its registered `sum`/`cout`. It compares every result against a golden `a+b` delayed by the wrapper latency, and reports pass/fail with a saturating error count and first-failure capture. It sits beside the wrapper in per-run self-test tops, so each topology gets a silicon/FPGA-checkable harness.

## Interface
- `WIDTH`, 8: operand width; supported values 4..16.
- `LATENCY`, 2: clock cycles from this block driving `a_out`/`b_out` to the matching `sum_in`/`cout_in`.
- `MODE`, 0: stimulus source. 0 = exhaustive. 1 = LFSR.
- `NUM_VECTORS`, 1024: vector count in MODE 1. Ignored in MODE 0.
- `SEED`, 1: LFSR seed of 2*WIDTH bits. A seed of 0 is replaced by 1.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a run
- `a_out`  out  WIDTH  operand A to the wrapper
- `b_out`  out  WIDTH  operand B to the wrapper
- `sum_in`  in  WIDTH  wrapper `sum`
- `cout_in`  in  1  wrapper `cout`
- `busy`  out  1  run in progress (RUN or DRAIN)
- `done`  out  1  run finished; held until the next start or reset
- `pass`  out  1  valid while `done`=1; equals (err_count==0)
- `err_count`  out  16  mismatches, saturating at 0xFFFF
- `first_err_a`, `first_err_b`  out  WIDTH each  operands of the first mismatch
- `first_err_got`  out  WIDTH+1  {cout_in,sum_in} observed at the first mismatch

## Operation
- FSM states and transitions:
  - IDLE: `start` → RUN.
  - RUN: after the last vector is driven → DRAIN.
  - DRAIN: after LATENCY cycles → DONE.
  - DONE: `start` → RUN.
- `start` is ignored in RUN and DRAIN.
- Entering RUN clears `err_count`, the first-error registers, `pass` and `done`, and reloads the vector generator.
- Vector count N:
  - MODE 0: N = 2^(2*WIDTH). Index counter `idx`; `a_out`=idx[2W-1:W], `b_out`=idx[W-1:0]; the first vector is a=0, b=0.
  - MODE 1: N = NUM_VECTORS. Fibonacci LFSR of 2*WIDTH bits, split the same way. The first vector is SEED; the LFSR advances once per driven vector.
- Every driven vector pushes {valid=1, expected=a+b of WIDTH+1 bits, a, b} into a LATENCY-deep shift pipe. Cycles that drive no vector push valid=0.
- When the pipe output is valid, {cout_in,sum_in} is compared to expected. On mismatch:
  - `err_count` increments, saturating at 0xFFFF.
  - If this is the first mismatch of the run, the operands and the observed value are latched into the first-error registers.
- `a_out`/`b_out` are registered. They hold the last vector through DRAIN and DONE.
- Reset mid-run forces IDLE, clears the pipe valid bits, and sets every output to its reset value. No compare is performed on the cycle after reset.
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, all first-error registers=0.

## Timing
- `start` is sampled at edge t0. `busy`=1 and vector 0 appear on `a_out`/`b_out` in cycle t0+1.
- Vector k is driven in cycle t0+1+k, for k = 0..N-1.
- Vector k is compared in cycle t0+1+k+LATENCY. `err_count` reflects that compare from the following cycle.
- `done`=1, `busy`=0 and `pass` become valid in cycle t0+N+LATENCY+1.
- Simultaneous `start` and `rst`: reset wins.
- MODE 0 wrap: `idx` reaching all-ones ends RUN. `idx` never wraps to 0 within a run.

## Structure
- Package `adder_selftest_pkg`:
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - Function `lfsr_taps(n)` returning maximal-length tap masks for n = 8..32.
  - Mode constants MODE_EXHAUSTIVE=0, MODE_LFSR=1.
- One natural sub-module, `selftest_vecgen`, containing the counter/LFSR with `load`, `advance` and `last` signals. FSM, expected pipe and checker stay in the top.

## Test plan
- Correct 8u wrapper, MODE 0 → `done` at cycle t0+65539, `pass`=1, `err_count`=0, final `a_out`=0xFF, `b_out`=0xFF.
- Wrapper `cout` forced to 0 only when a=0xFF, b=0x01, MODE 0 → `err_count`=1, `first_err_a`=0xFF, `first_err_b`=0x01, `first_err_got`=0x000, `pass`=0.
- `sum[0]` stuck-at-0, MODE 1 with NUM_VECTORS=1024 and SEED=1 → `err_count` equals the number of generated vectors with odd a+b (computed by a bench model), and `first_err_*` matches the model's first such vector.
- Wrapper with 3-cycle latency, LATENCY=2 → nonzero `err_count`, `pass`=0. Run again with LATENCY=3 → `pass`=1.
- `rst` pulsed at RUN cycle 100 → next cycle all outputs are 0 and state is IDLE. A fresh `start` then completes with `pass`=1.
- `start` pulsed during RUN and during DRAIN → no restart, and `done` occurs at the original t0+N+LATENCY+1.
